// File: rtl/ternary_mvm_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ternary_mvm_engine
//  Purpose  : OUT_LEN x IN_LEN ternary-weight matrix-vector multiply with
//             valid/ready streams for weights, inputs and results.
//             Define TMVM_SAT_EN to saturate results instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module ternary_mvm_engine #(
    parameter int IN_LEN  = 14,
    parameter int OUT_LEN = 7,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [2*IN_LEN-1:0]   w_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [IN_W-1:0]       x_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [OUT_W-1:0]      y_data,
    output logic                  y_last,
    output logic                  busy
);
    localparam int ACC_W   = IN_W + $clog2(IN_LEN + 1);
    localparam int c_COL_W = $clog2(IN_LEN);
    localparam int c_ROW_W = $clog2(OUT_LEN);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IN_LEN - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ACCUM = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_out_en;
    logic [2*IN_LEN-1:0]       r_w [OUT_LEN];
    logic signed [ACC_W-1:0]   r_acc [OUT_LEN];
    logic signed [ACC_W-1:0]   w_acc_nxt [OUT_LEN];
    logic [c_COL_W-1:0]        r_col;
    logic [c_ROW_W-1:0]        r_row;
    logic [c_ROW_W-1:0]        w_row_inc;
    logic                      r_y_valid;
    logic [OUT_W-1:0]          r_y_data;
    logic                      r_y_last;
    logic signed [ACC_W-1:0]   w_x_ext;
    logic                      w_w_fire;
    logic                      w_x_fire;
    logic                      w_y_fire;

`ifdef TMVM_SAT_EN
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

    function automatic logic [OUT_W-1:0] f_conv(input logic signed [ACC_W-1:0] a);
        if (a > c_SAT_MAX)
            return OUT_W'(c_SAT_MAX);
        else if (a < c_SAT_MIN)
            return OUT_W'(c_SAT_MIN);
        else
            return OUT_W'(a);
    endfunction
`else
    function automatic logic [OUT_W-1:0] f_conv(input logic signed [ACC_W-1:0] a);
        return OUT_W'(a);
    endfunction
`endif

    // r_out_en keeps x_ready low until the first edge after reset release
    assign w_ready = (r_state == S_LOAD);
    assign x_ready = r_out_en && ((r_state == S_IDLE) || (r_state == S_ACCUM));
    assign busy    = (r_state != S_IDLE);
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_last  = r_y_last;

    // load_start wins over a simultaneous x element in IDLE
    assign w_w_fire  = w_valid && w_ready;
    assign w_x_fire  = x_valid && x_ready && !((r_state == S_IDLE) && load_start);
    assign w_y_fire  = r_y_valid && y_ready;
    assign w_row_inc = r_row + 1'b1;
    assign w_x_ext   = {{(ACC_W - IN_W){x_data[IN_W-1]}}, x_data};

    always_comb begin
        for (int i = 0; i < OUT_LEN; i++) begin
            w_acc_nxt[i] = r_acc[i];
            case (r_w[i][{r_col, 1'b0} +: 2])
                2'b01:   w_acc_nxt[i] = r_acc[i] + w_x_ext;
                2'b11:   w_acc_nxt[i] = r_acc[i] - w_x_ext;
                default: w_acc_nxt[i] = r_acc[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start)
                    w_state_nxt = S_LOAD;
                else if (w_x_fire)
                    w_state_nxt = S_ACCUM;
            end
            S_LOAD: begin
                if (w_w_fire && (r_row == c_ROW_LAST))
                    w_state_nxt = S_IDLE;
            end
            S_ACCUM: begin
                if (w_x_fire && (r_col == c_COL_LAST))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_y_fire && (r_row == c_ROW_LAST))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en  <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_last  <= 1'b0;
            for (int i = 0; i < OUT_LEN; i++) begin
                r_w[i]   <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            r_out_en <= 1'b1;
            if (w_w_fire) begin
                r_w[r_row] <= w_data;
                r_row      <= (r_row == c_ROW_LAST) ? '0 : w_row_inc;
            end
            if (w_x_fire) begin
                for (int i = 0; i < OUT_LEN; i++)
                    r_acc[i] <= w_acc_nxt[i];
                if (r_col == c_COL_LAST) begin
                    // row 0 result comes straight from the final column update
                    r_col     <= '0;
                    r_row     <= '0;
                    r_y_valid <= 1'b1;
                    r_y_data  <= f_conv(w_acc_nxt[0]);
                    r_y_last  <= (c_ROW_LAST == '0);
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_y_fire) begin
                if (r_row == c_ROW_LAST) begin
                    r_row     <= '0;
                    r_y_valid <= 1'b0;
                    r_y_last  <= 1'b0;
                    for (int i = 0; i < OUT_LEN; i++)
                        r_acc[i] <= '0;
                end else begin
                    r_row    <= w_row_inc;
                    r_y_data <= f_conv(r_acc[w_row_inc]);
                    r_y_last <= (w_row_inc == c_ROW_LAST);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ternary_mvm_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ternary_mvm_engine
//  Purpose  : Self-checking bench for ternary_mvm_engine against an integer
//             matrix-vector reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_mvm_engine;
    localparam int IN_LEN  = 14;
    localparam int OUT_LEN = 7;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_start;
    logic                w_valid;
    logic                w_ready;
    logic [2*IN_LEN-1:0] w_data;
    logic                x_valid;
    logic                x_ready;
    logic [IN_W-1:0]     x_data;
    logic                y_valid;
    logic                y_ready;
    logic [OUT_W-1:0]    y_data;
    logic                y_last;
    logic                busy;

    int                  checks = 0;
    int                  errors = 0;
    int                  wm [OUT_LEN][IN_LEN];
    logic signed [IN_W-1:0] xv [IN_LEN];

    ternary_mvm_engine #(
        .IN_LEN (IN_LEN),
        .OUT_LEN(OUT_LEN),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_data    (y_data),
        .y_last    (y_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] conv(input int a);
        int v;
        v = a;
`ifdef TMVM_SAT_EN
        if (v > (1 << (OUT_W - 1)) - 1) v = (1 << (OUT_W - 1)) - 1;
        if (v < -(1 << (OUT_W - 1)))    v = -(1 << (OUT_W - 1));
`endif
        return v[OUT_W-1:0];
    endfunction

    function automatic logic [2*IN_LEN-1:0] enc_row(input int r);
        logic [2*IN_LEN-1:0] row;
        row = '0;
        for (int j = 0; j < IN_LEN; j++) begin
            if (wm[r][j] == 1)       row[2*j +: 2] = 2'b01;
            else if (wm[r][j] == -1) row[2*j +: 2] = 2'b11;
            else                     row[2*j +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        end
        return row;
    endfunction

    task automatic do_load(input bit pulse, input bit gaps);
        if (pulse) begin
            load_start = 1'b1;
            step();
            load_start = 1'b0;
        end
        check("load_wready", w_ready, 1);
        check("load_busy", busy, 1);
        for (int r = 0; r < OUT_LEN; r++) begin
            if (gaps && ($urandom_range(0, 1) != 0)) begin
                w_valid = 1'b0;
                step();
            end
            w_valid = 1'b1;
            w_data  = enc_row(r);
            step();
        end
        w_valid = 1'b0;
        check("load_done", {w_ready, busy}, 0);
    endtask

    task automatic run_vec(input bit gap_x, input bit bp_y, input bit ls_pulse,
                           input int stop_after, input bit chk_thru);
        logic [OUT_W-1:0] exp_y [OUT_LEN];
        int  acc;
        int  ncyc;
        int  got;
        int  guard;
        int  stall;
        bit  holding;
        logic [OUT_W:0] held;

        for (int i = 0; i < OUT_LEN; i++) begin
            acc = 0;
            for (int j = 0; j < IN_LEN; j++)
                acc += wm[i][j] * int'(xv[j]);
            exp_y[i] = conv(acc);
        end

        ncyc = 0;
        for (int j = 0; j < IN_LEN; j++) begin
            if (gap_x) begin
                x_valid = 1'b0;
                step();
            end
            x_valid    = 1'b1;
            x_data     = xv[j];
            load_start = ls_pulse && (j == 5);
            guard = 0;
            while (!x_ready && guard < 40) begin
                step();
                guard++;
            end
            if (guard >= 40) begin
                check("x_timeout", 0, 1);
                x_valid = 1'b0;
                load_start = 1'b0;
                return;
            end
            step();
            ncyc++;
            load_start = 1'b0;
        end
        x_valid = 1'b0;
        check("yv_rise", y_valid, 1);

        got = 0; guard = 0; stall = 0; holding = 0; held = '0;
        while (got < OUT_LEN && guard < 200) begin
            if (bp_y && got == 3 && stall < 3) begin
                y_ready = 1'b0;
                stall++;
            end else begin
                y_ready = bp_y ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (holding)
                check("hold", {y_last, y_data}, held);
            holding = 0;
            if (y_valid && y_ready) begin
                check("y_data", y_data, exp_y[got]);
                check("y_last", y_last, (got == OUT_LEN - 1));
                got++;
            end else if (y_valid) begin
                holding = 1;
                held = {y_last, y_data};
            end
            step();
            ncyc++;
            guard++;
            if (got == stop_after) begin
                y_ready = 1'b0;
                return;
            end
        end
        y_ready = 1'b0;
        check("y_count", got, OUT_LEN);
        check("post_idle", {y_valid, busy}, 0);
        if (chk_thru)
            check("thru", ncyc, IN_LEN + OUT_LEN);
    endtask

    task automatic rand_x();
        for (int j = 0; j < IN_LEN; j++)
            xv[j] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    endtask

    task automatic rand_w();
        for (int i = 0; i < OUT_LEN; i++)
            for (int j = 0; j < IN_LEN; j++)
                wm[i][j] = int'($urandom_range(0, 2)) - 1;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; w_valid = 1'b0; w_data = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {w_ready, x_ready, y_valid, y_data, y_last, busy}, 0);
        rst = 1'b0;
        check("xr_pre", x_ready, 0);
        step();
        check("xr_post", x_ready, 1);
        check("busy_idle", busy, 0);

        // never loaded: all-zero results
        rand_x();
        run_vec(0, 0, 0, -1, 1);

        // identity-style weights, x = 1..IN_LEN
        for (int i = 0; i < OUT_LEN; i++)
            for (int j = 0; j < IN_LEN; j++)
                wm[i][j] = (i == j) ? 1 : 0;
        for (int j = 0; j < IN_LEN; j++)
            xv[j] = IN_W'(j + 1);
        do_load(1, 0);
        run_vec(0, 0, 0, -1, 1);

        // large magnitude: row 0 all +1, rest all -1, x all 100
        for (int i = 0; i < OUT_LEN; i++)
            for (int j = 0; j < IN_LEN; j++)
                wm[i][j] = (i == 0) ? 1 : -1;
        for (int j = 0; j < IN_LEN; j++)
            xv[j] = 8'sd100;
        do_load(1, 1);
        run_vec(0, 0, 0, -1, 1);
        run_vec(0, 1, 0, -1, 0);

        // random weights/vectors with stalls and ignored load_start
        for (int t = 0; t < 4; t++) begin
            rand_w();
            do_load(1, 1);
            rand_x();
            run_vec(0, 0, 0, -1, 1);
            run_vec(1, 0, 1, -1, 0);
            run_vec(t[0], 1, 0, -1, 0);
        end

        // load_start and x_valid together in IDLE
        rand_w();
        rand_x();
        load_start = 1'b1;
        x_valid    = 1'b1;
        x_data     = xv[0];
        step();
        load_start = 1'b0;
        check("conflict_xr", x_ready, 0);
        do_load(0, 0);
        run_vec(0, 0, 0, -1, 1);

        // reset during drain after three results
        rand_x();
        run_vec(0, 0, 0, 3, 0);
        rst = 1'b1;
        #1;
        check("rst_drain", {y_valid, busy}, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < OUT_LEN; i++)
            for (int j = 0; j < IN_LEN; j++)
                wm[i][j] = 0;
        step();
        check("rst_recover", {x_ready, busy, y_valid}, 3'b100);
        rand_x();
        run_vec(0, 0, 0, -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
